comparator_nbit: RTL and testbench

- Registered N-bit magnitude comparator. Compares operands A and B and returns a one-hot 3-bit relation code R (greater / equal / less).
- One pipeline register stage. Sits in datapath control logic wherever a registered compare result is needed, e.g. threshold checks and sort/select stages.
- Instantiated with N=4 in the block-level bench.

---
 rtl/comparator_nbit.sv | 68 ++++++
 tb/tb_comparator_nbit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_nbit.sv
// Registered N-bit magnitude comparator producing a one-hot {gt, eq, lt} code.
// Latency: 1 clock from operand capture to R/out_valid. Throughput: 1 compare/clock.
// Backpressure: none; in_valid is a capture enable, and R holds while in_valid is low.
module comparator_nbit #(
   parameter int N      = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         in_valid,
   output logic [2:0]   R,
   output logic         out_valid
);

   // In signed mode, inverting the sign bit maps two's-complement order onto
   // unsigned order, so one unsigned cascade serves both modes. Equality is
   // unaffected because both operands get the same bit flipped.
   localparam logic [N-1:0] L_SIGN_MASK = SIGNED ? (N'(1) << (N - 1)) : '0;

   logic [N-1:0] w_a_ord;
   logic [N-1:0] w_b_ord;
   logic         w_gt;
   logic         w_lt;
   logic         w_eq;

   logic [2:0]   r_rel;
   logic         r_vld;

   assign w_a_ord = A ^ L_SIGN_MASK;
   assign w_b_ord = B ^ L_SIGN_MASK;

   // MSB-first bit-slice cascade: the first differing bit decides the relation.
   always_comb begin
      w_gt = 1'b0;
      w_lt = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!w_gt && !w_lt) begin
            if (w_a_ord[i] && !w_b_ord[i]) begin
               w_gt = 1'b1;
            end else if (!w_a_ord[i] && w_b_ord[i]) begin
               w_lt = 1'b1;
            end
         end
      end
   end

   // Equal only when no slice resolved a difference, which keeps the code one-hot.
   assign w_eq = ~(w_gt | w_lt);

   // Capture the relation on a valid cycle; hold R and drop out_valid otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rel <= 3'b000;
         r_vld <= 1'b0;
      end else if (in_valid) begin
         r_rel <= {w_gt, w_eq, w_lt};
         r_vld <= 1'b1;
      end else begin
         r_vld <= 1'b0;
      end
   end

   assign R         = r_rel;
   assign out_valid = r_vld;

endmodule

// File: tb/tb_comparator_nbit.sv
// Bench for comparator_nbit: unsigned and signed instances share one stimulus stream.
// Expected codes are queued at issue time and popped by per-instance monitors.
// Reset, hold and mid-stream reset behaviour are checked directly by the stimulus process.
module tb_comparator_nbit;

   localparam int N = 4;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         in_valid = 1'b0;
   logic [N-1:0] A        = '0;
   logic [N-1:0] B        = '0;

   logic [2:0]   r_u;
   logic [2:0]   r_s;
   logic         ov_u;
   logic         ov_s;

   logic [2:0]   q_u[$];
   logic [2:0]   q_s[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   comparator_nbit #(.N(N), .SIGNED(1'b0)) u_dut_u (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .R         (r_u),
      .out_valid (ov_u)
   );

   comparator_nbit #(.N(N), .SIGNED(1'b1)) u_dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .R         (r_s),
      .out_valid (ov_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference relation: integer compare after optional sign extension.
   function automatic logic [2:0] ref_rel(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      if (sgn) begin
         if (a[N-1]) ia -= (1 << N);
         if (b[N-1]) ib -= (1 << N);
      end
      if (ia > ib)       return 3'b100;
      else if (ia == ib) return 3'b010;
      else               return 3'b001;
   endfunction

   // Unsigned-instance monitor.
   always @(negedge clk) begin
      if (ov_u === 1'b1) begin
         if (q_u.size() == 0) begin
            n_checks++;
            $display("FAIL u_unexpected_out: got R=%b with no expected entry at %0t", r_u, $time);
         end else begin
            logic [2:0] e;
            e = q_u.pop_front();
            check("u_R", 32'(r_u), 32'(e));
            check("u_onehot", $countones(r_u), 1);
         end
      end
   end

   // Signed-instance monitor.
   always @(negedge clk) begin
      if (ov_s === 1'b1) begin
         if (q_s.size() == 0) begin
            n_checks++;
            $display("FAIL s_unexpected_out: got R=%b with no expected entry at %0t", r_s, $time);
         end else begin
            logic [2:0] e;
            e = q_s.pop_front();
            check("s_R", 32'(r_s), 32'(e));
            check("s_onehot", $countones(r_s), 1);
         end
      end
   end

   task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic v);
      @(posedge clk);
      #1;
      A        = a;
      B        = b;
      in_valid = v;
   endtask

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] exp_u, input logic [2:0] exp_s);
      drive(a, b, 1'b1);
      q_u.push_back(exp_u);
      q_s.push_back(exp_s);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_R_u"},  32'(r_u),  32'd0);
      check({tag, "_R_s"},  32'(r_s),  32'd0);
      check({tag, "_ov_u"}, 32'(ov_u), 32'd0);
      check({tag, "_ov_s"}, 32'(ov_s), 32'd0);
   endtask

   // Directed vectors: {A, B, expected unsigned, expected signed}.
   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   eu;
      logic [2:0]   es;
   } vec_t;

   vec_t sweep[10] = '{
      '{4'd0,  4'd0,  3'b010, 3'b010},
      '{4'd3,  4'd14, 3'b001, 3'b100},
      '{4'd8,  4'd8,  3'b010, 3'b010},
      '{4'd11, 4'd9,  3'b100, 3'b100},
      '{4'd15, 4'd7,  3'b100, 3'b001},
      '{4'd6,  4'd1,  3'b100, 3'b100},
      '{4'd3,  4'd3,  3'b010, 3'b010},
      '{4'd5,  4'd10, 3'b001, 3'b100},
      '{4'd4,  4'd2,  3'b100, 3'b100},
      '{4'd0,  4'd1,  3'b001, 3'b001}
   };

   vec_t signed_vecs[4] = '{
      '{4'd15, 4'd7,  3'b100, 3'b001},
      '{4'd8,  4'd7,  3'b100, 3'b001},
      '{4'd14, 4'd12, 3'b100, 3'b100},
      '{4'd8,  4'd8,  3'b010, 3'b010}
   };

   // Watchdog: stop with a report if the run stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      // Reset held with a valid operand pair present: nothing may be captured.
      rst_n    = 1'b0;
      A        = 4'd5;
      B        = 4'd3;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_cleared("reset");
      end

      // Release; the next edge captures (5,3).
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_u.push_back(3'b100);
      q_s.push_back(3'b100);

      foreach (sweep[i]) send(sweep[i].a, sweep[i].b, sweep[i].eu, sweep[i].es);

      // Hold: R keeps its value while in_valid is low.
      send(4'd11, 4'd9, 3'b100, 3'b100);
      drive(4'd0, 4'd15, 1'b0);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_R_u",  32'(r_u),  32'b100);
         check("hold_R_s",  32'(r_s),  32'b100);
         check("hold_ov_u", 32'(ov_u), 32'd0);
         check("hold_ov_s", 32'(ov_s), 32'd0);
      end

      foreach (signed_vecs[i]) send(signed_vecs[i].a, signed_vecs[i].b, signed_vecs[i].eu, signed_vecs[i].es);

      // Mid-stream async reset: capture (11,9), present (0,15) and reset before it is taken.
      send(4'd11, 4'd9, 3'b100, 3'b100);
      drive(4'd0, 4'd15, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_cleared("async_rst");
      @(negedge clk);
      check_cleared("async_rst_discard");
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      A        = 4'd2;
      B        = 4'd2;
      in_valid = 1'b1;
      q_u.push_back(3'b010);
      q_s.push_back(3'b010);

      // Exhaustive sweep of all operand pairs for both modes.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(4'(a), 4'(b), ref_rel(4'(a), 4'(b), 1'b0), ref_rel(4'(a), 4'(b), 1'b1));
         end
      end
      drive(4'd0, 4'd0, 1'b0);

      // Drain the scoreboards within a bounded number of cycles.
      for (int k = 0; k < 20 && (q_u.size() != 0 || q_s.size() != 0); k++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain_q_u", q_u.size(), 0);
      check("drain_q_s", q_s.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
